// File: rtl/ar_arb_pkg.sv
// ---------------------------------------------------------------------------
// ar_arb_pkg
// Shared constants, types and helpers for the QoS read-request arbiter.
//   QOS_W_DEF   : default AXI QoS field width
//   WAIT_W      : width of each per-source anti-starvation wait counter
//   REQ_W_DEF   : default width of the opaque packed read request
//   NUM_SRC_DEF : default number of requesters
//   ar_slot_t   : output slot layout {req, qos, src} for the default build
//   mod_inc()   : increment modulo n with an explicit wrap, so it is also
//                 correct when n is not a power of two
// ---------------------------------------------------------------------------
package ar_arb_pkg;

  localparam int QOS_W_DEF   = 4;
  localparam int WAIT_W      = 8;
  localparam int REQ_W_DEF   = 53;
  localparam int NUM_SRC_DEF = 4;
  localparam int SRC_W_DEF   = $clog2(NUM_SRC_DEF);

  typedef struct packed {
    logic [REQ_W_DEF-1:0] req;
    logic [QOS_W_DEF-1:0] qos;
    logic [SRC_W_DEF-1:0] src;
  } ar_slot_t;

  function automatic int unsigned mod_inc(input int unsigned idx,
                                          input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/ar_qos_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_prio_picker
// Combinational priority picker with round-robin tie-break.
// Picks the valid source with the highest priority; among equal priorities
// the first one met when searching upward from rr_ptr_i (wrapping) wins.
//   valid_i     : per-source valid
//   prio_i      : per-source priority, source i at [i*PRIO_W +: PRIO_W]
//   rr_ptr_i    : index where the tie-break search starts
//   winner_o    : selected source index (0 when nothing is valid)
//   any_valid_o : at least one source is valid
// ---------------------------------------------------------------------------
module rr_prio_picker #(
  parameter  int NUM_SRC = 4,
  parameter  int PRIO_W  = 5,
  localparam int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]        valid_i,
  input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
  input  logic [SRC_W-1:0]          rr_ptr_i,
  output logic [SRC_W-1:0]          winner_o,
  output logic                      any_valid_o
);

  logic [PRIO_W-1:0] prio_arr [NUM_SRC];
  logic [PRIO_W-1:0] best_prio;
  logic [SRC_W:0]    idx_ext;
  logic [SRC_W-1:0]  idx;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign prio_arr[g] = prio_i[g*PRIO_W +: PRIO_W];
  end

  // Visiting sources in rotated order and replacing the candidate only on a
  // strictly greater priority makes the earliest-visited source win ties.
  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    best_prio   = '0;
    idx_ext     = '0;
    idx         = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx_ext = {1'b0, rr_ptr_i} + (SRC_W+1)'(k);
      if (idx_ext >= (SRC_W+1)'(NUM_SRC)) begin
        idx_ext = idx_ext - (SRC_W+1)'(NUM_SRC);
      end
      idx = idx_ext[SRC_W-1:0];
      if (valid_i[idx] && (!any_valid_o || (prio_arr[idx] > best_prio))) begin
        any_valid_o = 1'b1;
        best_prio   = prio_arr[idx];
        winner_o    = idx;
      end
    end
  end

endmodule

// File: rtl/ar_qos_arbiter.sv
// ---------------------------------------------------------------------------
// ar_qos_arbiter
// Shares the single read-request path into the ID remapping unit among
// NUM_SRC request buffers. Each cycle one requester is picked by AXI QoS,
// with round-robin tie-break and age-based promotion of starved sources.
// The winner is registered into a one-entry output slot together with its
// source index, so response routing can later find its way back.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : per-source request valid
//   in_ready  : per-source accept, at most one bit high (combinational)
//   in_req    : per-source request, source i at [i*REQ_W +: REQ_W]
//   in_qos    : per-source QoS,     source i at [i*QOS_W +: QOS_W]
//   out_valid : output slot holds a request
//   out_ready : downstream accept
//   out_req   : granted request
//   out_qos   : granted QoS
//   out_src   : granted source index
// ---------------------------------------------------------------------------
module ar_qos_arbiter
  import ar_arb_pkg::*;
#(
  parameter  int NUM_SRC      = NUM_SRC_DEF,
  parameter  int REQ_W        = REQ_W_DEF,
  parameter  int QOS_W        = QOS_W_DEF,
  parameter  int STARVE_LIMIT = 8,
  localparam int SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC-1:0]       in_valid,
  output logic [NUM_SRC-1:0]       in_ready,
  input  logic [NUM_SRC*REQ_W-1:0] in_req,
  input  logic [NUM_SRC*QOS_W-1:0] in_qos,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [REQ_W-1:0]         out_req,
  output logic [QOS_W-1:0]         out_qos,
  output logic [SRC_W-1:0]         out_src
);

  localparam int PRIO_W = QOS_W + 1;

  typedef struct packed {
    logic [REQ_W-1:0] req;
    logic [QOS_W-1:0] qos;
    logic [SRC_W-1:0] src;
  } slot_t;

  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  slot_t                slot_q, slot_d;
  logic                 out_valid_q, out_valid_d;
  logic [SRC_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WAIT_W-1:0]    wait_q [NUM_SRC];
  logic [WAIT_W-1:0]    wait_d [NUM_SRC];

  logic [REQ_W-1:0]          req_arr [NUM_SRC];
  logic [QOS_W-1:0]          qos_arr [NUM_SRC];
  logic [NUM_SRC*PRIO_W-1:0] prio_vec;
  logic [SRC_W-1:0]          winner;
  logic                      any_valid;
  logic                      slot_free;
  logic                      grant;

  // Effective priority {starved, qos}: a starved source outranks every
  // non-starved one, and QoS still orders sources within each class.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign req_arr[g] = in_req[g*REQ_W +: REQ_W];
    assign qos_arr[g] = in_qos[g*QOS_W +: QOS_W];
    assign prio_vec[g*PRIO_W +: PRIO_W] =
      {(wait_q[g] >= WAIT_W'(STARVE_LIMIT)), qos_arr[g]};

    // Age only while waiting; a grant or a dropped valid restarts the count.
    // Backpressure does not stop aging.
    always_comb begin
      wait_d[g] = '0;
      if (in_valid[g] && !(grant && (winner == SRC_W'(g)))) begin
        wait_d[g] = sat_inc(wait_q[g]);
      end
    end
  end

  rr_prio_picker #(
    .NUM_SRC (NUM_SRC),
    .PRIO_W  (PRIO_W)
  ) u_picker (
    .valid_i     (in_valid),
    .prio_i      (prio_vec),
    .rr_ptr_i    (rr_ptr_q),
    .winner_o    (winner),
    .any_valid_o (any_valid)
  );

  // The slot can take a new request when empty or when it drains this cycle.
  assign slot_free = !out_valid_q || out_ready;
  assign grant     = slot_free && any_valid;

  always_comb begin
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    rr_ptr_d    = rr_ptr_q;
    in_ready    = '0;
    if (grant) begin
      in_ready[winner] = 1'b1;
      slot_d.req       = req_arr[winner];
      slot_d.qos       = qos_arr[winner];
      slot_d.src       = winner;
      out_valid_d      = 1'b1;
      rr_ptr_d         = SRC_W'(mod_inc(32'(winner), NUM_SRC));
    end else if (out_ready) begin
      // Drain with nothing to replace it; data registers hold.
      out_valid_d = 1'b0;
    end
  end

  // Output slot / arbitration state boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q      <= '0;
      out_valid_q <= 1'b0;
      rr_ptr_q    <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wait_q[i] <= '0;
      end
    end else begin
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      rr_ptr_q    <= rr_ptr_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        wait_q[i] <= wait_d[i];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_req   = slot_q.req;
  assign out_qos   = slot_q.qos;
  assign out_src   = slot_q.src;

endmodule

// File: tb/tb_ar_qos_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ar_qos_arbiter
// Directed bench for ar_qos_arbiter. dut_a uses STARVE_LIMIT=4 (anti-
// starvation scenario), dut_b uses STARVE_LIMIT=255 (pure QoS ordering).
// ---------------------------------------------------------------------------
module tb_ar_qos_arbiter;

  localparam int N  = 4;
  localparam int RW = 53;
  localparam int QW = 4;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst;

  logic [N-1:0]    a_vld,  b_vld;
  logic [N*RW-1:0] a_req,  b_req;
  logic [N*QW-1:0] a_qos,  b_qos;
  logic            a_ordy, b_ordy;
  logic [N-1:0]    a_irdy, b_irdy;
  logic            a_ovld, b_ovld;
  logic [RW-1:0]   a_oreq, b_oreq;
  logic [QW-1:0]   a_oqos, b_oqos;
  logic [SW-1:0]   a_osrc, b_osrc;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ar_qos_arbiter #(
    .NUM_SRC(N), .REQ_W(RW), .QOS_W(QW), .STARVE_LIMIT(4)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_vld), .in_ready(a_irdy), .in_req(a_req), .in_qos(a_qos),
    .out_valid(a_ovld), .out_ready(a_ordy),
    .out_req(a_oreq), .out_qos(a_oqos), .out_src(a_osrc)
  );

  ar_qos_arbiter #(
    .NUM_SRC(N), .REQ_W(RW), .QOS_W(QW), .STARVE_LIMIT(255)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_vld), .in_ready(b_irdy), .in_req(b_req), .in_qos(b_qos),
    .out_valid(b_ovld), .out_ready(b_ordy),
    .out_req(b_oreq), .out_qos(b_oqos), .out_src(b_osrc)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag,
                         input logic ovld, input logic [SW-1:0] osrc,
                         input logic [RW-1:0] oreq, input logic [QW-1:0] oqos,
                         input logic evld, input logic [SW-1:0] esrc,
                         input logic [RW-1:0] ereq, input logic [QW-1:0] eqos);
    chk({tag, "_vld"}, 64'(ovld), 64'(evld));
    chk({tag, "_src"}, 64'(osrc), 64'(esrc));
    chk({tag, "_req"}, 64'(oreq), 64'(ereq));
    chk({tag, "_qos"}, 64'(oqos), 64'(eqos));
  endtask

  task automatic drive_a(input int i, input logic v,
                         input logic [RW-1:0] r, input logic [QW-1:0] q);
    a_vld[i]          = v;
    a_req[i*RW +: RW] = r;
    a_qos[i*QW +: QW] = q;
  endtask

  task automatic drive_b(input int i, input logic v,
                         input logic [RW-1:0] r, input logic [QW-1:0] q);
    b_vld[i]          = v;
    b_req[i*RW +: RW] = r;
    b_qos[i*QW +: QW] = q;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    rst    = 1'b0;
    a_vld  = '0; a_req = '0; a_qos = '0; a_ordy = 1'b0;
    b_vld  = '0; b_req = '0; b_qos = '0; b_ordy = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk_out("rst_a", a_ovld, a_osrc, a_oreq, a_oqos, 1'b0, 2'd0, '0, 4'd0);
    chk("rst_a_irdy", 64'(a_irdy), 64'd0);
    chk("rst_b_vld", 64'(b_ovld), 64'd0);
    #9 rst = 1'b0;
    tick();

    // Round-robin among four equal-QoS sources held valid
    a_ordy = 1'b1;
    for (int s = 0; s < N; s++) drive_a(s, 1'b1, RW'(64'h100 + 64'(s)), 4'd0);
    #1;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      chk("rr_irdy", 64'(a_irdy), 64'(1) << e);
      tick();
      chk_out("rr_out", a_ovld, a_osrc, a_oreq, a_oqos,
              1'b1, SW'(e), RW'(64'h100 + 64'(e)), 4'd0);
    end
    for (int s = 0; s < N; s++) drive_a(s, 1'b0, '0, 4'd0);
    #1 chk("rr_idle_irdy", 64'(a_irdy), 64'd0);
    tick();
    chk("rr_drain_vld", 64'(a_ovld), 64'd0);

    // Single source
    drive_a(2, 1'b1, RW'(64'hA5), 4'd3);
    #1 chk("single_irdy", 64'(a_irdy), 64'b0100);
    tick();
    chk_out("single_out", a_ovld, a_osrc, a_oreq, a_oqos,
            1'b1, 2'd2, RW'(64'hA5), 4'd3);
    drive_a(2, 1'b0, '0, 4'd0);
    tick();
    chk("single_drain_vld", 64'(a_ovld), 64'd0);

    // Anti-starvation: src1 promoted after 4 cycles of waiting
    drive_a(0, 1'b1, RW'(64'h40), 4'd15);
    drive_a(1, 1'b1, RW'(64'h41), 4'd0);
    #1;
    for (int k = 0; k < 6; k++) begin
      e = (k == 4) ? 1 : 0;
      chk("starve_irdy", 64'(a_irdy), 64'(1) << e);
      tick();
      chk_out("starve_out", a_ovld, a_osrc, a_oreq, a_oqos, 1'b1, SW'(e),
              RW'(64'h40 + 64'(e)), (e == 1) ? 4'd0 : 4'd15);
    end
    drive_a(0, 1'b0, '0, 4'd0);
    drive_a(1, 1'b0, '0, 4'd0);
    tick();
    chk("starve_drain_vld", 64'(a_ovld), 64'd0);

    // Backpressure
    drive_a(0, 1'b1, RW'(64'h55), 4'd0);
    #1 chk("bp_first_irdy", 64'(a_irdy), 64'b0001);
    tick();
    chk_out("bp_first", a_ovld, a_osrc, a_oreq, a_oqos,
            1'b1, 2'd0, RW'(64'h55), 4'd0);
    drive_a(0, 1'b0, '0, 4'd0);
    drive_a(1, 1'b1, RW'(64'h66), 4'd2);
    a_ordy = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_irdy", 64'(a_irdy), 64'd0);
      tick();
      chk_out("bp_hold", a_ovld, a_osrc, a_oreq, a_oqos,
              1'b1, 2'd0, RW'(64'h55), 4'd0);
    end
    a_ordy = 1'b1;
    #1 chk("bp_release_irdy", 64'(a_irdy), 64'b0010);
    tick();
    chk_out("bp_release", a_ovld, a_osrc, a_oreq, a_oqos,
            1'b1, 2'd1, RW'(64'h66), 4'd2);
    drive_a(1, 1'b0, '0, 4'd0);
    a_ordy = 1'b0;
    tick();
    chk_out("bp_stall", a_ovld, a_osrc, a_oreq, a_oqos,
            1'b1, 2'd1, RW'(64'h66), 4'd2);

    // Reset between clock edges while the slot is full and stalled
    #3 rst = 1'b1;
    #1;
    chk_out("midrst", a_ovld, a_osrc, a_oreq, a_oqos, 1'b0, 2'd0, '0, 4'd0);
    #1 rst = 1'b0;
    for (int s = 0; s < N; s++) drive_a(s, 1'b1, RW'(64'h200 + 64'(s)), 4'd0);
    a_ordy = 1'b1;
    #1 chk("postrst_irdy", 64'(a_irdy), 64'b0001);
    tick();
    chk_out("postrst", a_ovld, a_osrc, a_oreq, a_oqos,
            1'b1, 2'd0, RW'(64'h200), 4'd0);
    for (int s = 0; s < N; s++) drive_a(s, 1'b0, '0, 4'd0);
    tick();
    chk("postrst_drain_vld", 64'(a_ovld), 64'd0);

    // QoS ordering with starvation effectively disabled (dut_b)
    b_ordy = 1'b1;
    drive_b(0, 1'b1, RW'(64'h10), 4'd1);
    drive_b(3, 1'b1, RW'(64'h13), 4'd9);
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("qos_irdy", 64'(b_irdy), 64'b1000);
      tick();
      chk_out("qos_hi", b_ovld, b_osrc, b_oreq, b_oqos,
              1'b1, 2'd3, RW'(64'h13), 4'd9);
    end
    drive_b(3, 1'b0, '0, 4'd0);
    #1 chk("qos_lo_irdy", 64'(b_irdy), 64'b0001);
    tick();
    chk_out("qos_lo", b_ovld, b_osrc, b_oreq, b_oqos,
            1'b1, 2'd0, RW'(64'h10), 4'd1);
    drive_b(0, 1'b0, '0, 4'd0);
    tick();
    chk("qos_drain_vld", 64'(b_ovld), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ar_qos_arbiter.md
Name: ar_qos_arbiter

Overview:
Shares the single read-request path into the ID remapping unit among NUM_SRC incoming request buffers. Each cycle it picks one requester using AXI QoS priority, with round-robin tie-break and age-based anti-starvation. It registers the winning request into a one-entry output slot with valid/ready handshake. The source index travels with the request so later response routing can use it.

Parameters:
NUM_SRC, 4, number of requesters (2..16)
REQ_W, 53, width of opaque packed request (id, addr, len, size, burst, tagid)
QOS_W, 4, AXI QoS field width
STARVE_LIMIT, 8, cycles a valid, ungranted requester waits before promotion (1..255)

Ports:
clk  in  1  clock
rst  in  1  reset
in_valid  in  NUM_SRC  per-source request valid
in_ready  out  NUM_SRC  per-source accept; at most one bit high
in_req  in  NUM_SRC*REQ_W  per-source request; source i at bits [i*REQ_W +: REQ_W]
in_qos  in  NUM_SRC*QOS_W  per-source QoS; source i at [i*QOS_W +: QOS_W]
out_valid  out  1  output slot holds a request
out_ready  in  1  downstream accept
out_req  out  REQ_W  granted request
out_qos  out  QOS_W  granted QoS
out_src  out  SRC_W  granted source index; SRC_W = $clog2(NUM_SRC)

Behaviour:
- Reset: asynchronous, active-high; clock clk. While rst is high: out_valid=0, out_req=0, out_qos=0, out_src=0, rr_ptr=0, all wait counters=0. in_ready is combinational and 0 while out_valid is 0 and there is no input valid.
- slot_free = !out_valid || out_ready.
- Effective priority of source i: QOS_W+1 bits = {starved_i, qos_i}. starved_i = (wait_cnt_i >= STARVE_LIMIT). A starved source beats any non-starved one; among starved sources QoS still orders.
- Winner: the highest effective priority among sources with in_valid set. Ties go to the first index found searching upward from rr_ptr, wrapping modulo NUM_SRC.
- Grant: if slot_free and any in_valid, then in_ready[winner]=1 and all other bits are 0. Otherwise in_ready is all 0.
- On a grant edge:
  - out_req, out_qos and out_src load the winner's data.
  - out_valid <= 1.
  - rr_ptr <= (winner+1) mod NUM_SRC. The wrap must be explicit for non-power-of-2 NUM_SRC.
- If out_ready is high, out_valid is high and no source is valid: out_valid <= 0 and data registers hold.
- Latency: request accepted at edge N appears on out_* from edge N. Back-to-back grants every cycle are possible while out_ready stays high (full throughput).
- Backpressure: while out_valid && !out_ready, out_* stay stable and no grant is made.
- Simultaneous drain and grant in the same cycle: out_* is replaced with the new winner and out_valid stays 1.
- Wait counters, 8 bits per source:
  - Cleared when the source is granted or its in_valid is low.
  - Otherwise incremented, saturating at 255.
  - Counters increment even during output backpressure.
- No grant lock is needed. Sources must hold in_valid and data until in_ready (AXI rule); the arbiter may re-pick a different winner each cycle until a grant occurs.
- in_qos and in_req of sources with in_valid low are ignored.
- Reset mid-operation: a pending out request is discarded and out_valid drops immediately (asynchronous reset).

Decomposition:
- Package ar_arb_pkg:
  - QOS_W default constant.
  - Wait-counter width constant (8).
  - Function for modulo-NUM_SRC increment.
  - Packed struct of the output slot {req, qos, src}.
- Sub-module rr_prio_picker: combinational, parameterised by NUM_SRC and PRIO_W.
  - Inputs: valid vector, packed priority vector, rr_ptr.
  - Outputs: winner index, any_valid.
  - Verified standalone before integration.

Test Plan:
1. Single source: NUM_SRC=4, only src2 valid with req=0xA5, qos=3, out_ready=1. Expected: in_ready=0100 in the same cycle; next cycle out_valid=1, out_req=0xA5, out_src=2.
2. Round-robin tie: all four sources valid, qos=0, held, out_ready=1. Expected: grants in order 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
3. QoS priority: src0 qos=1, src3 qos=9, both valid, STARVE_LIMIT=255. Expected: src3 granted every cycle while valid; src0 granted only once src3 deasserts.
4. Anti-starvation: STARVE_LIMIT=4, src1 qos=0 valid, src0 qos=15 continuously valid. Expected: src0 wins 4 cycles, then src1 is granted on the 5th cycle and its counter clears.
5. Backpressure: grant src0, then out_ready=0 for 5 cycles with src1 valid. Expected: out_* stable, in_ready=0000 throughout; on out_ready=1, src1 is accepted in that cycle and appears on the next edge.
6. Reset mid-operation: out_valid=1 with out_ready=0, assert rst between clock edges. Expected: out_valid=0 immediately and rr_ptr=0. After release with all sources valid, the first grant goes to src0.
